dr_mem_bridge: RTL and testbench

- Parametrised successor to the 8-bit data register: a DR_WIDTH-bit data register loadable from the internal bus, with clear/increment ops and a multi-beat memory read/write handshake engine.
- Sits between the CPU internal bus and a narrow memory port; the control unit issues single-cycle op strobes and waits on busy/done.

---
 rtl/dr_mem_bridge.sv | 136 +++++++++++++
 tb/tb_dr_mem_bridge.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dr_mem_bridge.sv
// Data register with clear/load/increment ops and a multi-beat memory read/write engine.
// Register ops take effect on the next falling edge; a transfer takes 1 + BEATS + 1 falling edges with zero-wait acks.
// Each beat holds mem_req until mem_ack; ops and starts are dropped while a transfer is running.
// Optional per-beat ack timeout with sticky err: define DR_TIMEOUT_EN.
module dr_mem_bridge #(
   parameter int DR_WIDTH  = 8,
   parameter int BUS_WIDTH = 16,
   parameter int MEM_WIDTH = 8,
   parameter int TIMEOUT   = 15,
   localparam int BEATS    = DR_WIDTH / MEM_WIDTH,
   localparam int BW       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [BUS_WIDTH-1:0] bus,
   input  logic                 drload,
   input  logic                 drclr,
   input  logic                 drinc,
   input  logic                 rd_start,
   input  logic                 wr_start,
   input  logic [MEM_WIDTH-1:0] mem_rdata,
   input  logic                 mem_ack,
   output logic [DR_WIDTH-1:0]  dr_out,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [BW-1:0]        mem_beat,
   output logic [MEM_WIDTH-1:0] mem_wdata,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_FIN} state_t;

   state_t               r_state;
   state_t               w_next;
   logic [DR_WIDTH-1:0]  r_dr;
   logic [DR_WIDTH-1:0]  r_shadow;
   logic [BW-1:0]        r_beat;
   logic                 r_we;
   logic                 w_idle;
   logic                 w_xfer;
   logic                 w_start;
   logic                 w_last;
   logic                 w_tmo;
   logic                 w_unused;

   assign w_idle  = (r_state == S_IDLE);
   assign w_xfer  = (r_state == S_XFER);
   // A start only wins when no register op is strobed in the same cycle.
   assign w_start = w_idle & ~drclr & ~drload & ~drinc & (rd_start | wr_start);
   assign w_last  = (r_beat == BW'(BEATS - 1));
   // Upper bus bits are outside the register and intentionally dropped.
   assign w_unused = ^bus;

   assign dr_out    = r_dr;
   assign mem_req   = w_xfer;
   assign mem_we    = w_xfer & r_we;
   assign mem_beat  = r_beat;
   // Write data comes from the snapshot so mid-transfer ops cannot disturb it.
   assign mem_wdata = r_shadow[r_beat*MEM_WIDTH +: MEM_WIDTH];
   assign busy      = w_xfer;
   assign done      = (r_state == S_FIN);

`ifdef DR_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] r_cnt;
   logic          r_err;

   assign w_tmo = w_xfer & ~mem_ack & (r_cnt == TW'(TIMEOUT - 1));
   assign err   = r_err;

   // Per-beat ack wait counter and sticky timeout flag.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else if (w_xfer && !mem_ack && !w_tmo) begin
         r_cnt <= r_cnt + TW'(1);
      end else begin
         r_cnt <= '0;
         if (w_tmo) r_err <= 1'b1;
      end
   end
`else
   assign w_tmo = 1'b0;
   assign err   = 1'b0;
`endif

   // State register.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state: IDLE -> XFER on start, XFER -> FIN on last ack or timeout, FIN -> IDLE.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_next = S_XFER;
         S_XFER:  if ((mem_ack && w_last) || w_tmo) w_next = S_FIN;
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Data register ops, transfer setup and per-beat datapath.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dr     <= '0;
         r_shadow <= '0;
         r_beat   <= '0;
         r_we     <= 1'b0;
      end else if (w_idle) begin
         if (drclr) begin
            r_dr <= '0;
         end else if (drload) begin
            r_dr <= bus[DR_WIDTH-1:0];
         end else if (drinc) begin
            r_dr <= r_dr + DR_WIDTH'(1);
         end else if (rd_start || wr_start) begin
            r_we     <= ~rd_start;
            r_shadow <= r_dr;
            r_beat   <= '0;
         end
      end else if (w_xfer) begin
         if (mem_ack) begin
            if (!r_we) r_dr[r_beat*MEM_WIDTH +: MEM_WIDTH] <= mem_rdata;
            r_beat <= w_last ? '0 : r_beat + BW'(1);
         end else if (w_tmo) begin
            r_beat <= '0;
         end
      end
   end

endmodule

// File: tb/tb_dr_mem_bridge.sv
// Directed bench for dr_mem_bridge: an 8-bit instance for register ops, a 16-bit one for two-beat transfers.
// Inputs change just after each falling edge; outputs are sampled 1 time unit after it.
// Define DR_TIMEOUT_EN at build time to also exercise the ack timeout path (TIMEOUT=4 on the 16-bit instance).
module tb_dr_mem_bridge;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // 8-bit instance signals
   logic [15:0] a_bus = '0;
   logic        a_load = 0, a_clr = 0, a_inc = 0, a_rd = 0, a_wr = 0, a_ack = 0;
   logic [7:0]  a_rdata = '0;
   logic [7:0]  a_dr, a_wdata;
   logic        a_req, a_we, a_busy, a_done, a_err;
   logic [0:0]  a_beat;

   // 16-bit instance signals
   logic [15:0] b_bus = '0;
   logic        b_load = 0, b_clr = 0, b_inc = 0, b_rd = 0, b_wr = 0, b_ack = 0;
   logic [7:0]  b_rdata = '0;
   logic [15:0] b_dr;
   logic [7:0]  b_wdata;
   logic        b_req, b_we, b_busy, b_done, b_err;
   logic [0:0]  b_beat;

   dr_mem_bridge u8 (
      .clk(clk), .rst_n(rst_n), .bus(a_bus), .drload(a_load), .drclr(a_clr), .drinc(a_inc),
      .rd_start(a_rd), .wr_start(a_wr), .mem_rdata(a_rdata), .mem_ack(a_ack),
      .dr_out(a_dr), .mem_req(a_req), .mem_we(a_we), .mem_beat(a_beat), .mem_wdata(a_wdata),
      .busy(a_busy), .done(a_done), .err(a_err));

   dr_mem_bridge #(.DR_WIDTH(16), .BUS_WIDTH(16), .MEM_WIDTH(8), .TIMEOUT(4)) u16 (
      .clk(clk), .rst_n(rst_n), .bus(b_bus), .drload(b_load), .drclr(b_clr), .drinc(b_inc),
      .rd_start(b_rd), .wr_start(b_wr), .mem_rdata(b_rdata), .mem_ack(b_ack),
      .dr_out(b_dr), .mem_req(b_req), .mem_we(b_we), .mem_beat(b_beat), .mem_wdata(b_wdata),
      .busy(b_busy), .done(b_done), .err(b_err));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   typedef struct {
      logic        clr, load, inc, rd;
      logic [15:0] bus;
      logic [7:0]  exp_dr;
   } vec_t;

   vec_t vecs[12];

   initial begin
      vecs[0]  = '{0, 1, 0, 0, 16'hA5C3, 8'hC3};
      vecs[1]  = '{0, 0, 1, 0, 16'h0000, 8'hC4};
      vecs[2]  = '{0, 1, 0, 0, 16'h00FF, 8'hFF};
      vecs[3]  = '{0, 0, 1, 0, 16'h0000, 8'h00};
      vecs[4]  = '{0, 1, 0, 0, 16'h0055, 8'h55};
      vecs[5]  = '{1, 1, 0, 0, 16'h0011, 8'h00};
      vecs[6]  = '{0, 1, 1, 0, 16'h0042, 8'h42};
      vecs[7]  = '{1, 0, 1, 0, 16'h0000, 8'h00};
      vecs[8]  = '{0, 0, 0, 0, 16'hFFFF, 8'h00};
      vecs[9]  = '{0, 0, 1, 0, 16'h0000, 8'h01};
      vecs[10] = '{0, 1, 0, 0, 16'h1280, 8'h80};
      vecs[11] = '{0, 0, 1, 1, 16'h0000, 8'h81};

      // Reset state
      step(); step();
      chk("rst_dr8", {24'h0, a_dr}, 32'h0);
      chk("rst_req8", {31'h0, a_req}, 32'h0);
      chk("rst_busy8", {31'h0, a_busy}, 32'h0);
      chk("rst_done8", {31'h0, a_done}, 32'h0);
      chk("rst_dr16", {16'h0, b_dr}, 32'h0);
      chk("rst_err16", {31'h0, b_err}, 32'h0);
      rst_n = 1'b1;
      step();

      // Register op priority table on the 8-bit instance
      for (int i = 0; i < 12; i++) begin
         a_clr = vecs[i].clr; a_load = vecs[i].load; a_inc = vecs[i].inc;
         a_rd = vecs[i].rd;   a_bus = vecs[i].bus;
         step();
         chk($sformatf("vec%0d_dr", i), {24'h0, a_dr}, {24'h0, vecs[i].exp_dr});
         chk($sformatf("vec%0d_busy", i), {31'h0, a_busy}, 32'h0);
      end
      a_clr = 0; a_load = 0; a_inc = 0; a_rd = 0;

      // Single-beat read on the 8-bit instance
      a_rd = 1; step(); a_rd = 0;
      chk("r8_req", {31'h0, a_req}, 32'h1);
      chk("r8_we", {31'h0, a_we}, 32'h0);
      chk("r8_beat", {31'h0, a_beat}, 32'h0);
      a_ack = 1; a_rdata = 8'h5A; step(); a_ack = 0;
      chk("r8_done", {31'h0, a_done}, 32'h1);
      chk("r8_dr", {24'h0, a_dr}, 32'h5A);
      chk("r8_req_off", {31'h0, a_req}, 32'h0);
      step();
      chk("r8_done_off", {31'h0, a_done}, 32'h0);

      // ack in IDLE is ignored
      b_ack = 1; b_rdata = 8'hFF; step(); b_ack = 0;
      chk("idle_ack_dr", {16'h0, b_dr}, 32'h0);
      chk("idle_ack_busy", {31'h0, b_busy}, 32'h0);

      // Two-beat read: 0x34 then 0x12
      b_rd = 1; step(); b_rd = 0;
      chk("rd_busy", {31'h0, b_busy}, 32'h1);
      chk("rd_we", {31'h0, b_we}, 32'h0);
      chk("rd_beat0", {31'h0, b_beat}, 32'h0);
      b_ack = 1; b_rdata = 8'h34; step();
      chk("rd_beat1", {31'h0, b_beat}, 32'h1);
      chk("rd_dr_half", {16'h0, b_dr}, 32'h0034);
      chk("rd_req_held", {31'h0, b_req}, 32'h1);
      b_rdata = 8'h12; step(); b_ack = 0;
      chk("rd_done", {31'h0, b_done}, 32'h1);
      chk("rd_dr", {16'h0, b_dr}, 32'h1234);
      chk("rd_busy_fin", {31'h0, b_busy}, 32'h0);
      step();
      chk("rd_done_once", {31'h0, b_done}, 32'h0);
      chk("rd_busy_after", {31'h0, b_busy}, 32'h0);

      // Write 0xBEEF with 3-cycle ack delay and drload strobed mid-transfer
      b_load = 1; b_bus = 16'hBEEF; step(); b_load = 0;
      chk("wr_preload", {16'h0, b_dr}, 32'hBEEF);
      b_wr = 1; step(); b_wr = 0;
      chk("wr_we", {31'h0, b_we}, 32'h1);
      chk("wr_wdata0", {24'h0, b_wdata}, 32'hEF);
      for (int k = 0; k < 3; k++) begin
         b_load = (k == 1); b_bus = 16'h0000;
         step();
         chk($sformatf("wr_wait0_%0d", k), {24'h0, b_wdata, 6'h0, b_req, b_beat}, 32'hEF02);
      end
      b_load = 0;
      b_ack = 1; step(); b_ack = 0;
      chk("wr_wdata1", {24'h0, b_wdata}, 32'hBE);
      chk("wr_beat1", {31'h0, b_beat}, 32'h1);
      for (int k = 0; k < 3; k++) begin
         b_inc = (k == 0); b_clr = (k == 2);
         step();
         chk($sformatf("wr_wait1_%0d", k), {24'h0, b_wdata, 6'h0, b_req, b_we}, 32'hBE03);
      end
      b_inc = 0; b_clr = 0;
      b_ack = 1; step(); b_ack = 0;
      chk("wr_done", {31'h0, b_done}, 32'h1);
      chk("wr_dr_kept", {16'h0, b_dr}, 32'hBEEF);
      step();

      // rd_start and wr_start together: read wins
      b_rd = 1; b_wr = 1; step(); b_rd = 0; b_wr = 0;
      chk("rdwr_we", {31'h0, b_we}, 32'h0);
      chk("rdwr_req", {31'h0, b_req}, 32'h1);
      b_ack = 1; b_rdata = 8'h00; step(); step(); b_ack = 0;
      chk("rdwr_done", {31'h0, b_done}, 32'h1);
      chk("rdwr_dr", {16'h0, b_dr}, 32'h0000);
      step();

`ifdef DR_TIMEOUT_EN
      // Timeout: no ack, TIMEOUT=4
      b_rd = 1; step(); b_rd = 0;
      step(); step(); step();
      chk("tmo_req_before", {31'h0, b_req}, 32'h1);
      step();
      chk("tmo_req_drop", {31'h0, b_req}, 32'h0);
      chk("tmo_err", {31'h0, b_err}, 32'h1);
      chk("tmo_done", {31'h0, b_done}, 32'h1);
      step(); step();
      chk("tmo_err_sticky", {31'h0, b_err}, 32'h1);
`else
      chk("err_tied", {30'h0, a_err, b_err}, 32'h0);
`endif

      // Reset mid-transfer clears everything asynchronously
      b_load = 1; b_bus = 16'h1234; step(); b_load = 0;
      a_rd = 1; b_rd = 1; step(); a_rd = 0; b_rd = 0;
      chk("mid_busy8", {31'h0, a_busy}, 32'h1);
      chk("mid_busy16", {31'h0, b_busy}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_dr8", {24'h0, a_dr}, 32'h0);
      chk("arst_dr16", {16'h0, b_dr}, 32'h0);
      chk("arst_ctl8", {26'h0, a_req, a_we, a_beat, a_busy, a_done, a_err}, 32'h0);
      chk("arst_ctl16", {26'h0, b_req, b_we, b_beat, b_busy, b_done, b_err}, 32'h0);
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst_busy16", {31'h0, b_busy}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
